// File: rtl/tx_bpsk_pkg.sv
// Shared widths, state encoding and helper functions
// for the BPSK transmit upconverter.
package tx_bpsk_pkg;

  localparam int LUT_AW = 8;
  localparam int LUT_N  = 2 ** LUT_AW;
  localparam int CAR_W  = 18;
  localparam int AMP_W  = 17;
  localparam int OUT_W  = 16;
  localparam int PROD_W = AMP_W + CAR_W;
  localparam int SHIFT  = 18;
  localparam int CAR_PK = 131071;

  localparam real PI = 3.14159265358979323846;

  localparam logic signed [AMP_W-1:0] AMP_MIN =
    {1'b1, {(AMP_W-1){1'b0}}};
  localparam logic signed [AMP_W-1:0] AMP_CLAMP =
    AMP_MIN + AMP_W'(1);

  localparam logic signed [PROD_W-1:0] OUT_MAX =
    PROD_W'(2 ** (OUT_W-1) - 1);
  localparam logic signed [PROD_W-1:0] OUT_MIN =
    -OUT_MAX - PROD_W'(1);

  typedef enum logic {
    IDLE,
    RUN
  } state_t;

  function automatic logic signed [CAR_W-1:0] sin_lut(
    input int k
  );
    real x;
    int  r;
    x = real'(CAR_PK) *
      $sin(2.0 * PI * real'(k) / real'(LUT_N));
    if (x >= 0.0) r = $rtoi(x + 0.5);
    else          r = -$rtoi(0.5 - x);
    return CAR_W'(r);
  endfunction

  function automatic logic signed [OUT_W-1:0] sat_s(
    input logic signed [PROD_W-1:0] p
  );
    logic signed [PROD_W-1:0] s;
    s = p >>> SHIFT;
    if (s > OUT_MAX) return OUT_MAX[OUT_W-1:0];
    if (s < OUT_MIN) return OUT_MIN[OUT_W-1:0];
    return s[OUT_W-1:0];
  endfunction

endpackage

// File: rtl/tx_bpsk_mul_sat.sv
// Registered signed multiply, scale and saturate (3 stages),
// with a valid flag travelling alongside each stage.
module tx_bpsk_mul_sat
  import tx_bpsk_pkg::*;
(
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    ce,
  input  logic                    vin,
  input  logic signed [AMP_W-1:0] a,
  input  logic signed [CAR_W-1:0] b,
  output logic signed [OUT_W-1:0] y,
  output logic                    busy
);

  logic signed [AMP_W-1:0]  a1;
  logic signed [CAR_W-1:0]  b1;
  logic signed [PROD_W-1:0] p2;
  logic                     v1, v2, v3;

  always_ff @(posedge clk) begin
    if (reset) begin
      a1 <= '0;
      b1 <= '0;
      p2 <= '0;
      y  <= '0;
      v1 <= 1'b0;
      v2 <= 1'b0;
      v3 <= 1'b0;
    end else if (ce) begin
      a1 <= a;
      b1 <= b;
      p2 <= PROD_W'(a1) * PROD_W'(b1);
      y  <= sat_s(p2);
      v1 <= vin;
      v2 <= v1;
      v3 <= v2;
    end
  end

  assign busy = v1 | v2 | v3;

endmodule

// File: rtl/tx_bpsk_upconverter.sv
// BPSK symbol mapper, NCO and sine LUT feeding the
// multiply/saturate pipeline; one sample per ce.
module tx_bpsk_upconverter
  import tx_bpsk_pkg::*;
#(
  parameter int SPS     = 64,
  parameter int PHASE_W = 16
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    ce,
  input  logic [PHASE_W-1:0]      phase_inc,
  input  logic signed [AMP_W-1:0] amplitude,
  input  logic                    bit_in,
  input  logic                    bit_valid,
  output logic                    bit_ready,
  output logic signed [OUT_W-1:0] sample_out,
  output logic                    sample_valid,
  output logic                    tx_busy
);

  localparam int CNT_W = $clog2(SPS);

  state_t                  state, state_n;
  logic [CNT_W-1:0]        cnt, cnt_n;
  logic [PHASE_W-1:0]      phase, phase_n;
  logic signed [AMP_W-1:0] amp_reg, amp_n;
  logic                    bit_reg, bit_n;
  logic                    last, take;

  logic                    v0;
  logic signed [AMP_W-1:0] sym0;
  logic [LUT_AW-1:0]       addr0;
  logic                    pipe_busy;

  logic signed [CAR_W-1:0] lut [LUT_N];

  for (genvar i = 0; i < LUT_N; i++) begin : g_lut
    assign lut[i] = sin_lut(i);
  end

  assign last      = (cnt == CNT_W'(SPS - 1));
  assign bit_ready = !reset && (state == IDLE || last);
  assign take      = ce && bit_valid && bit_ready;

  always_comb begin
    state_n = state;
    cnt_n   = cnt;
    phase_n = phase;
    amp_n   = amp_reg;
    bit_n   = bit_reg;
    unique case (state)
      IDLE: begin
        if (take) begin
          state_n = RUN;
          cnt_n   = '0;
          phase_n = '0;
          bit_n   = bit_in;
          amp_n   = (amplitude == AMP_MIN) ?
                    AMP_CLAMP : amplitude;
        end
      end
      RUN: begin
        if (ce) begin
          phase_n = phase + phase_inc;
          cnt_n   = last ? '0 : cnt + CNT_W'(1);
          if (last) begin
            if (take) bit_n   = bit_in;
            else      state_n = IDLE;
          end
        end
      end
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state        <= IDLE;
      cnt          <= '0;
      phase        <= '0;
      amp_reg      <= '0;
      bit_reg      <= 1'b0;
      v0           <= 1'b0;
      sym0         <= '0;
      addr0        <= '0;
      sample_valid <= 1'b0;
    end else begin
      state        <= state_n;
      cnt          <= cnt_n;
      phase        <= phase_n;
      amp_reg      <= amp_n;
      bit_reg      <= bit_n;
      sample_valid <= ce;
      if (ce) begin
        v0    <= (state == RUN);
        addr0 <= phase[PHASE_W-1 -: LUT_AW];
        if (state == RUN)
          sym0 <= bit_reg ? amp_reg : -amp_reg;
        else
          sym0 <= '0;
      end
    end
  end

  tx_bpsk_mul_sat u_mul (
    .clk   (clk),
    .reset (reset),
    .ce    (ce),
    .vin   (v0),
    .a     (sym0),
    .b     (lut[addr0]),
    .y     (sample_out),
    .busy  (pipe_busy)
  );

  assign tx_busy = (state == RUN) || pipe_busy;

endmodule

// File: tb/tb_tx_bpsk_upconverter.sv
// Directed bench for tx_bpsk_upconverter with SPS=4 and
// quarter-turn phase steps.
module tb_tx_bpsk_upconverter;

  logic               clk;
  logic               reset;
  logic               ce;
  logic [15:0]        phase_inc;
  logic signed [16:0] amplitude;
  logic               bit_in;
  logic               bit_valid;
  logic               bit_ready;
  logic signed [15:0] sample_out;
  logic               sample_valid;
  logic               tx_busy;

  int checks = 0;
  int errors = 0;

  logic signed [15:0] pos_w [4];
  logic signed [15:0] neg_w [4];
  logic signed [15:0] clp_w [4];
  logic signed [15:0] ex;
  logic               exb;

  tx_bpsk_upconverter #(
    .SPS     (4),
    .PHASE_W (16)
  ) dut (
    .clk          (clk),
    .reset        (reset),
    .ce           (ce),
    .phase_inc    (phase_inc),
    .amplitude    (amplitude),
    .bit_in       (bit_in),
    .bit_valid    (bit_valid),
    .bit_ready    (bit_ready),
    .sample_out   (sample_out),
    .sample_valid (sample_valid),
    .tx_busy      (tx_busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog expired");
    $fatal(1);
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset     = 1'b1;
    ce        = 1'b0;
    bit_valid = 1'b0;
    bit_in    = 1'b0;
    tick();
    reset     = 1'b0;
  endtask

  task automatic accept(
    input logic               b,
    input logic signed [16:0] a
  );
    amplitude = a;
    bit_in    = b;
    bit_valid = 1'b1;
    ce        = 1'b1;
    tick();
  endtask

  task automatic test_reset();
    reset     = 1'b1;
    ce        = 1'b1;
    bit_valid = 1'b0;
    bit_in    = 1'b0;
    phase_inc = 16'd16384;
    amplitude = 17'sd32768;
    tick();
    tick();
    checks++;
    if (sample_out !== 16'sd0) begin
      errors++;
      $display("FAIL rst_out got %0d want 0", sample_out);
    end
    checks++;
    if (sample_valid !== 1'b0) begin
      errors++;
      $display("FAIL rst_valid got %b want 0", sample_valid);
    end
    checks++;
    if (tx_busy !== 1'b0) begin
      errors++;
      $display("FAIL rst_busy got %b want 0", tx_busy);
    end
    checks++;
    if (bit_ready !== 1'b0) begin
      errors++;
      $display("FAIL rst_ready got %b want 0", bit_ready);
    end
    reset = 1'b0;
    #1;
    checks++;
    if (bit_ready !== 1'b1) begin
      errors++;
      $display("FAIL idle_ready got %b want 1", bit_ready);
    end
  endtask

  task automatic test_single();
    do_reset();
    phase_inc = 16'd16384;
    accept(1'b1, 17'sd32768);
    bit_valid = 1'b0;
    checks++;
    if (tx_busy !== 1'b1) begin
      errors++;
      $display("FAIL single_busy0 got %b want 1", tx_busy);
    end
    for (int s = 1; s <= 9; s++) begin
      tick();
      ex  = (s >= 4 && s <= 7) ? pos_w[s-4] : 16'sd0;
      exb = (s <= 7);
      checks++;
      if (sample_out !== ex) begin
        errors++;
        $display("FAIL single_s%0d got %0d want %0d",
                 s, sample_out, ex);
      end
      checks++;
      if (tx_busy !== exb) begin
        errors++;
        $display("FAIL single_busy%0d got %b want %b",
                 s, tx_busy, exb);
      end
      checks++;
      if (sample_valid !== 1'b1) begin
        errors++;
        $display("FAIL single_sv%0d got %b want 1",
                 s, sample_valid);
      end
    end
  endtask

  task automatic test_back_to_back();
    do_reset();
    phase_inc = 16'd16384;
    accept(1'b1, 17'sd32768);
    bit_in = 1'b0;
    checks++;
    if (bit_ready !== 1'b0) begin
      errors++;
      $display("FAIL b2b_rdy0 got %b want 0", bit_ready);
    end
    for (int s = 1; s <= 12; s++) begin
      tick();
      if (s == 4) bit_valid = 1'b0;
      if (s >= 4 && s <= 7)       ex = pos_w[s-4];
      else if (s >= 8 && s <= 11) ex = neg_w[s-8];
      else                        ex = 16'sd0;
      exb = (s >= 8) || (s % 4 == 3);
      checks++;
      if (sample_out !== ex) begin
        errors++;
        $display("FAIL b2b_s%0d got %0d want %0d",
                 s, sample_out, ex);
      end
      checks++;
      if (bit_ready !== exb) begin
        errors++;
        $display("FAIL b2b_rdy%0d got %b want %b",
                 s, bit_ready, exb);
      end
    end
  endtask

  task automatic test_clamp();
    do_reset();
    phase_inc = 16'd16384;
    accept(1'b0, 17'h10000);
    bit_valid = 1'b0;
    for (int s = 1; s <= 8; s++) begin
      tick();
      ex = (s >= 4 && s <= 7) ? clp_w[s-4] : 16'sd0;
      checks++;
      if (sample_out !== ex) begin
        errors++;
        $display("FAIL clamp_s%0d got %0d want %0d",
                 s, sample_out, ex);
      end
    end
  endtask

  task automatic test_ce_gaps();
    int n;
    int cec;
    int svc;
    do_reset();
    phase_inc = 16'd16384;
    accept(1'b1, 17'sd32768);
    bit_valid = 1'b0;
    n   = 0;
    cec = 0;
    svc = 0;
    for (int t = 0; t < 300 && n < 9; t++) begin
      ce = 1'($urandom_range(0, 1));
      tick();
      if (sample_valid) svc++;
      if (ce) begin
        n++;
        cec++;
        ex = (n >= 4 && n <= 7) ? pos_w[n-4] : 16'sd0;
        checks++;
        if (sample_out !== ex) begin
          errors++;
          $display("FAIL gaps_s%0d got %0d want %0d",
                   n, sample_out, ex);
        end
      end
    end
    ce = 1'b1;
    checks++;
    if (n != 9) begin
      errors++;
      $display("FAIL gaps_bound got %0d strobes want 9", n);
    end
    checks++;
    if (svc != cec) begin
      errors++;
      $display("FAIL gaps_svcnt got %0d want %0d", svc, cec);
    end
  endtask

  task automatic test_reset_mid();
    do_reset();
    phase_inc = 16'd16384;
    accept(1'b1, 17'sd32768);
    bit_valid = 1'b0;
    for (int s = 1; s <= 5; s++) tick();
    checks++;
    if (sample_out !== 16'sd16383) begin
      errors++;
      $display("FAIL mid_pre got %0d want 16383", sample_out);
    end
    reset = 1'b1;
    tick();
    checks++;
    if (sample_out !== 16'sd0) begin
      errors++;
      $display("FAIL mid_out got %0d want 0", sample_out);
    end
    checks++;
    if (tx_busy !== 1'b0) begin
      errors++;
      $display("FAIL mid_busy got %b want 0", tx_busy);
    end
    checks++;
    if (sample_valid !== 1'b0) begin
      errors++;
      $display("FAIL mid_sv got %b want 0", sample_valid);
    end
    reset = 1'b0;
    #1;
    checks++;
    if (bit_ready !== 1'b1) begin
      errors++;
      $display("FAIL mid_rdy got %b want 1", bit_ready);
    end
    for (int s = 1; s <= 8; s++) begin
      tick();
      checks++;
      if (sample_out !== 16'sd0 || tx_busy !== 1'b0) begin
        errors++;
        $display("FAIL mid_flush%0d got %0d/%b want 0/0",
                 s, sample_out, tx_busy);
      end
    end
  endtask

  task automatic test_gap();
    do_reset();
    phase_inc = 16'd16384;
    accept(1'b1, 17'sd32768);
    bit_valid = 1'b0;
    for (int s = 1; s <= 16; s++) begin
      if (s == 8) begin
        bit_in    = 1'b0;
        bit_valid = 1'b1;
      end
      tick();
      if (s == 8) bit_valid = 1'b0;
      if (s >= 4 && s <= 7)        ex = pos_w[s-4];
      else if (s >= 12 && s <= 15) ex = neg_w[s-12];
      else                         ex = 16'sd0;
      checks++;
      if (sample_out !== ex) begin
        errors++;
        $display("FAIL gap_s%0d got %0d want %0d",
                 s, sample_out, ex);
      end
    end
  endtask

  initial begin
    pos_w = '{16'sd0, 16'sd16383, 16'sd0, -16'sd16384};
    neg_w = '{16'sd0, -16'sd16384, 16'sd0, 16'sd16383};
    clp_w = '{16'sd0, 16'sd32767, 16'sd0, -16'sd32768};
    test_reset();
    test_single();
    test_back_to_back();
    test_clamp();
    test_ce_gaps();
    test_reset_mid();
    test_gap();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
